// File: rtl/tone_detect_pkg.sv
// Shared types and constants for the FFT-bin tone detector: tone bin table,
// FSM states, candidate encoding and energy-width helper.
package tone_detect_pkg;

  localparam int MAG_W     = 17;
  localparam int MAX_TONES = 8;
  localparam int ID_W      = $clog2(MAX_TONES);

  // Centre bin of each tone; every entry sits inside SPREAD..FFT_SIZE/2-1-SPREAD.
  localparam int TONE_BIN [MAX_TONES] = '{40, 60, 80, 120, 160, 200, 240, 300};

  typedef enum logic [1:0] {ACCUM, DECIDE, UPDATE, REPORT} state_t;

  // A candidate is either a tone index or SILENCE; SILENCE doubles as "none reported".
  typedef struct packed {
    logic            silent;
    logic [ID_W-1:0] id;
  } cand_t;

  localparam cand_t SILENCE = '{silent: 1'b1, id: '0};

  function automatic int energy_w(input int spread);
    return MAG_W + $clog2(2 * spread + 1);
  endfunction

endpackage

// File: rtl/fft_bin_magnitude.sv
// One registered stage: accepted FFT beat -> |re|+|im| magnitude plus its bin index.
module fft_bin_magnitude
  import tone_detect_pkg::*;
#(
  parameter int BW = 11
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_valid,
  input  logic [31:0]      i_tdata,
  input  logic [BW-1:0]    i_bin,
  output logic             o_valid,
  output logic [MAG_W-1:0] o_mag,
  output logic [BW-1:0]    o_bin
);

  logic signed [16:0] w_re;
  logic signed [16:0] w_im;
  logic [MAG_W-1:0]   w_abs_re;
  logic [MAG_W-1:0]   w_abs_im;

  // Sign-extend to 17 bits first so |-32768| is representable.
  assign w_re     = $signed({i_tdata[15], i_tdata[15:0]});
  assign w_im     = $signed({i_tdata[31], i_tdata[31:16]});
  assign w_abs_re = w_re[16] ? $unsigned(-w_re) : $unsigned(w_re);
  assign w_abs_im = w_im[16] ? $unsigned(-w_im) : $unsigned(w_im);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      o_valid <= 1'b0;
      o_mag   <= '0;
      o_bin   <= '0;
    end else begin
      o_valid <= i_valid;
      o_mag   <= w_abs_re + w_abs_im;
      o_bin   <= i_bin;
    end
  end

endmodule

// File: rtl/tone_bin_detector.sv
// Multi-tone detector: windowed energy per configured bin, per-frame argmax,
// debounced tone report over a valid/ready handshake.
module tone_bin_detector
  import tone_detect_pkg::*;
#(
  parameter  int FFT_SIZE    = 2048,
  parameter  int NUM_TONES   = 8,
  parameter  int SPREAD      = 1,
  parameter  int HOLD_FRAMES = 3,
  localparam int EW          = energy_w(SPREAD),
  localparam int IW          = $clog2(NUM_TONES)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          fft_tvalid,
  output logic          fft_tready,
  input  logic          fft_tlast,
  input  logic [31:0]   fft_tdata,
  input  logic [EW-1:0] threshold,
  output logic          tone_valid,
  input  logic          tone_ready,
  output logic [IW-1:0] tone_ident,
  output logic [EW-1:0] tone_energy,
  output logic          frame_error
);

  localparam int              BW       = $clog2(FFT_SIZE);
  localparam int              HW       = $clog2(HOLD_FRAMES + 1);
  localparam logic [BW-1:0]   LAST_BIN = BW'(FFT_SIZE - 1);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_TONES - 1);

  state_t          r_state;
  logic            r_done;
  logic            r_tready;
  logic            r_valid;
  logic            r_frame_error;
  logic [BW-1:0]   r_count;
  logic [EW-1:0]   r_acc [NUM_TONES];
  logic [ID_W-1:0] r_idx;
  logic [EW-1:0]   r_best_e;
  logic [ID_W-1:0] r_best_i;
  cand_t           r_cand;
  cand_t           r_prev;
  cand_t           r_last;
  logic [HW-1:0]   r_hold;
  logic [IW-1:0]   r_ident;
  logic [EW-1:0]   r_energy;

  logic             w_accept;
  logic             w_end_ok;
  logic             w_bad;
  logic             w_acc_clr;
  logic             w_mag_valid;
  logic [MAG_W-1:0] w_mag;
  logic [BW-1:0]    w_mag_bin;
  logic             w_take;
  logic [EW-1:0]    w_new_e;
  logic [ID_W-1:0]  w_new_i;
  cand_t            w_cand;
  logic [HW-1:0]    w_hold_next;
  logic             w_stable;
  logic             w_report;

  assign fft_tready  = r_tready;
  assign tone_valid  = r_valid;
  assign tone_ident  = r_ident;
  assign tone_energy = r_energy;
  assign frame_error = r_frame_error;

  // A frame is malformed when tlast and "count is at the last bin" disagree.
  assign w_accept  = fft_tvalid & r_tready;
  assign w_end_ok  = w_accept & fft_tlast & (r_count == LAST_BIN);
  assign w_bad     = w_accept & (fft_tlast ^ (r_count == LAST_BIN));
  assign w_acc_clr = w_bad | (r_state == UPDATE);

  fft_bin_magnitude #(.BW(BW)) u_mag (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_valid (w_accept & ~w_bad),
    .i_tdata (fft_tdata),
    .i_bin   (r_count),
    .o_valid (w_mag_valid),
    .o_mag   (w_mag),
    .o_bin   (w_mag_bin)
  );

  // NOTE: the accumulators are a handful of flops, not a RAM, so they take the reset like any other state.
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < NUM_TONES; k++) begin
      if (rst_in || w_acc_clr) begin
        r_acc[k] <= '0;
      end else if (w_mag_valid && w_mag_bin >= BW'(TONE_BIN[k] - SPREAD)
                               && w_mag_bin <= BW'(TONE_BIN[k] + SPREAD)) begin
        r_acc[k] <= r_acc[k] + EW'(w_mag);
      end
    end
  end

  // Running argmax; strict '>' keeps the lowest index on ties.
  assign w_take  = (r_idx == '0) || (r_acc[r_idx] > r_best_e);
  assign w_new_e = w_take ? r_acc[r_idx] : r_best_e;
  assign w_new_i = w_take ? r_idx : r_best_i;

  always_comb begin
    w_cand = SILENCE;
    if (w_new_e >= threshold) w_cand = '{silent: 1'b0, id: w_new_i};
  end

  assign w_hold_next = (r_cand != r_prev)                ? HW'(1) :
                       (r_hold == HW'(HOLD_FRAMES))      ? r_hold : r_hold + 1'b1;
  assign w_stable    = (w_hold_next == HW'(HOLD_FRAMES));
  assign w_report    = w_stable && !r_cand.silent && (r_cand != r_last);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= ACCUM;
      r_done        <= 1'b0;
      r_tready      <= 1'b0;
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
      r_count       <= '0;
      r_idx         <= '0;
      r_best_e      <= '0;
      r_best_i      <= '0;
      r_cand        <= SILENCE;
      r_prev        <= SILENCE;
      r_last        <= SILENCE;
      r_hold        <= '0;
      r_ident       <= '0;
      r_energy      <= '0;
    end else begin
      r_frame_error <= w_bad;
      case (r_state)
        ACCUM: begin
          if (r_done) begin
            // Last beat's magnitude lands in the accumulators this cycle.
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_state <= DECIDE;
          end else if (w_end_ok) begin
            r_done   <= 1'b1;
            r_tready <= 1'b0;
            r_count  <= '0;
          end else begin
            r_tready <= 1'b1;
            if (w_bad) begin
              r_count <= '0;
              r_hold  <= '0;
            end else if (w_accept) begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        DECIDE: begin
          r_best_e <= w_new_e;
          r_best_i <= w_new_i;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cand  <= w_cand;
            r_state <= UPDATE;
          end
        end
        UPDATE: begin
          r_prev <= r_cand;
          r_hold <= w_hold_next;
          if (w_report) begin
            r_last   <= r_cand;
            r_ident  <= r_cand.id[IW-1:0];
            r_energy <= r_best_e;
            r_valid  <= 1'b1;
            r_state  <= REPORT;
          end else begin
            if (w_stable && r_cand.silent) r_last <= SILENCE;
            r_tready <= 1'b1;
            r_state  <= ACCUM;
          end
        end
        REPORT: begin
          if (tone_ready) begin
            r_valid  <= 1'b0;
            r_tready <= 1'b1;
            r_state  <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_bin_detector.sv
// Directed bench for tone_bin_detector: full 2048-bin frames with hand-computed energies.
module tb_tone_bin_detector;
  import tone_detect_pkg::*;

  localparam int FFT_SIZE = 2048;
  localparam int EW       = 19;
  localparam int IW       = 3;

  logic          clk_in     = 1'b0;
  logic          rst_in     = 1'b1;
  logic          fft_tvalid = 1'b0;
  logic          fft_tlast  = 1'b0;
  logic [31:0]   fft_tdata  = '0;
  logic [EW-1:0] threshold  = '0;
  logic          tone_ready = 1'b1;
  logic          fft_tready;
  logic          tone_valid;
  logic [IW-1:0] tone_ident;
  logic [EW-1:0] tone_energy;
  logic          frame_error;

  int            vectors     = 0;
  int            miscompares = 0;
  int            rep_cnt     = 0;
  int            err_cnt     = 0;
  logic [IW-1:0] rep_ident   = '0;
  logic [EW-1:0] rep_energy  = '0;
  int            stim_bin  [4];
  logic [31:0]   stim_data [4];
  int            n_stim    = 0;
  int            base;
  int            ebase;

  tone_bin_detector #(
    .FFT_SIZE(FFT_SIZE), .NUM_TONES(8), .SPREAD(1), .HOLD_FRAMES(3)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .fft_tvalid  (fft_tvalid),
    .fft_tready  (fft_tready),
    .fft_tlast   (fft_tlast),
    .fft_tdata   (fft_tdata),
    .threshold   (threshold),
    .tone_valid  (tone_valid),
    .tone_ready  (tone_ready),
    .tone_ident  (tone_ident),
    .tone_energy (tone_energy),
    .frame_error (frame_error)
  );

  always #5 clk_in = ~clk_in;

  // Observe completed report handshakes and error pulses mid-cycle.
  always begin
    @(negedge clk_in);
    #1;
    if (tone_valid && tone_ready) begin
      rep_cnt++;
      rep_ident  = tone_ident;
      rep_energy = tone_energy;
    end
    if (frame_error) err_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    n_stim = 0;
  endtask

  task automatic add_stim(input int bin, input int re, input int im);
    stim_bin[n_stim]  = bin;
    stim_data[n_stim] = {16'(im), 16'(re)};
    n_stim++;
  endtask

  function automatic logic [31:0] beat_data(input int bin);
    logic [31:0] d;
    d = '0;
    for (int s = 0; s < n_stim; s++) if (stim_bin[s] == bin) d = stim_data[s];
    return d;
  endfunction

  task automatic send_beat(input int bin, input logic last);
    int waited;
    waited = 0;
    @(negedge clk_in);
    while (!fft_tready) begin
      fft_tvalid = 1'b0;
      waited++;
      if (waited > 200) begin
        $display("FAIL tready_wait bin %0d: observed 0 expected 1", bin);
        $fatal(1, "fft_tready never returned");
      end
      @(negedge clk_in);
    end
    fft_tvalid = 1'b1;
    fft_tlast  = last;
    fft_tdata  = beat_data(bin);
    @(posedge clk_in);
    #1 fft_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int nbins);
    for (int i = 0; i < nbins; i++) send_beat(i, i == nbins - 1);
  endtask

  task automatic settle();
    repeat (14) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in     = 1'b1;
    fft_tvalid = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_tready", fft_tready, 0);
    check("rst_valid", tone_valid, 0);
    check("rst_ident", tone_ident, 0);
    check("rst_energy", tone_energy, 0);
    check("rst_ferr", frame_error, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_tready", fft_tready, 1);

    // Tone 3 at 1000, threshold 500: one report after 3 frames, exact latency
    threshold = 500;
    clear_stim();
    add_stim(TONE_BIN[3], 1000, 0);
    base = rep_cnt;
    send_frame(FFT_SIZE); settle();
    send_frame(FFT_SIZE); settle();
    check("t1_no_early_report", rep_cnt - base, 0);
    send_frame(FFT_SIZE);
    @(negedge clk_in);
    check("t1_tready_busy", fft_tready, 0);
    repeat (9) @(negedge clk_in);
    check("t1_valid_before", tone_valid, 0);
    @(negedge clk_in);
    check("t1_valid_rise", tone_valid, 1);
    check("t1_ident", tone_ident, 3);
    check("t1_energy", tone_energy, 1000);
    check("t1_tready_in_report", fft_tready, 0);
    @(negedge clk_in);
    check("t1_valid_drop", tone_valid, 0);
    settle();
    check("t1_one_report", rep_cnt - base, 1);
    send_frame(FFT_SIZE); settle();
    send_frame(FFT_SIZE); settle();
    check("t1_no_repeat", rep_cnt - base, 1);

    // Same tone, threshold 2000: silence every frame
    do_reset();
    threshold = 2000;
    base  = rep_cnt;
    ebase = err_cnt;
    send_frame(FFT_SIZE); settle();
    send_frame(FFT_SIZE); settle();
    send_frame(FFT_SIZE);
    repeat (10) @(negedge clk_in);
    check("t2_tready_still_low", fft_tready, 0);
    @(negedge clk_in);
    check("t2_tready_return", fft_tready, 1);
    settle();
    check("t2_no_report", rep_cnt - base, 0);
    check("t2_no_ferr", err_cnt - ebase, 0);

    // Tie at 800 between tones 2 and 5, energy equal to threshold
    do_reset();
    threshold = 800;
    clear_stim();
    add_stim(TONE_BIN[2], -600, 200);
    add_stim(TONE_BIN[5], 300, -500);
    base = rep_cnt;
    repeat (3) begin send_frame(FFT_SIZE); settle(); end
    check("t3_reports", rep_cnt - base, 1);
    check("t3_ident", rep_ident, 2);
    check("t3_energy", rep_energy, 800);

    // Early tlast, then windowed tone 1 (500 + 400 in window, 700 just outside)
    do_reset();
    threshold = 500;
    clear_stim();
    add_stim(TONE_BIN[1] - 1, 500, 0);
    add_stim(TONE_BIN[1], 0, -400);
    add_stim(TONE_BIN[1] + 2, 700, 0);
    base  = rep_cnt;
    ebase = err_cnt;
    send_frame(101);
    @(negedge clk_in);
    check("t4_ferr_pulse", frame_error, 1);
    @(negedge clk_in);
    check("t4_ferr_clear", frame_error, 0);
    repeat (3) begin send_frame(FFT_SIZE); settle(); end
    check("t4_reports", rep_cnt - base, 1);
    check("t4_ident", rep_ident, 1);
    check("t4_energy", rep_energy, 900);
    check("t4_ferr_count", err_cnt - ebase, 1);

    // Tone 4 with consumer stalled, then repeat / silence / repeat
    do_reset();
    threshold = 500;
    clear_stim();
    add_stim(TONE_BIN[4], 1500, 0);
    tone_ready = 1'b0;
    base = rep_cnt;
    send_frame(FFT_SIZE); settle();
    send_frame(FFT_SIZE); settle();
    send_frame(FFT_SIZE);
    repeat (11) @(negedge clk_in);
    for (int c = 0; c < 50; c++) begin
      check("t5_hold_valid", tone_valid, 1);
      check("t5_hold_ident", tone_ident, 4);
      check("t5_hold_energy", tone_energy, 1500);
      check("t5_hold_tready", fft_tready, 0);
      @(negedge clk_in);
    end
    tone_ready = 1'b1;
    @(negedge clk_in);
    check("t5_handshake", tone_valid, 0);
    check("t5_first_report", rep_cnt - base, 1);
    repeat (3) begin send_frame(FFT_SIZE); settle(); end
    check("t5_same_tone_quiet", rep_cnt - base, 1);
    clear_stim();
    repeat (3) begin send_frame(FFT_SIZE); settle(); end
    check("t5_silence_quiet", rep_cnt - base, 1);
    add_stim(TONE_BIN[4], 1500, 0);
    repeat (3) begin send_frame(FFT_SIZE); settle(); end
    check("t5_second_report", rep_cnt - base, 2);
    check("t5_second_ident", rep_ident, 4);

    // Reset pulse mid-frame clears outputs and the hold history
    clear_stim();
    add_stim(TONE_BIN[6], 1200, 0);
    base  = rep_cnt;
    ebase = err_cnt;
    send_frame(FFT_SIZE); settle();
    for (int i = 0; i <= 1024; i++) send_beat(i, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("t6_rst_tready", fft_tready, 0);
    check("t6_rst_valid", tone_valid, 0);
    check("t6_rst_ident", tone_ident, 0);
    check("t6_rst_energy", tone_energy, 0);
    check("t6_rst_ferr", frame_error, 0);
    rst_in = 1'b0;
    send_frame(FFT_SIZE); settle();
    send_frame(FFT_SIZE); settle();
    check("t6_no_early_report", rep_cnt - base, 0);
    send_frame(FFT_SIZE); settle();
    check("t6_report", rep_cnt - base, 1);
    check("t6_ident", rep_ident, 6);
    check("t6_energy", rep_energy, 1200);
    check("t6_no_ferr", err_cnt - ebase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_bin_detector.md
# tone_bin_detector

Parametrised multi-tone detector on the FFT output stream. Consumes one FFT frame of `FFT_SIZE` complex bins over a valid/ready/last handshake, sums magnitude energy in a small window around each of `NUM_TONES` configured bins, and selects the strongest tone per frame. Reports a debounced tone identifier over a valid/ready output. Sits between the FFT core and the tone-decoding logic, replacing the fixed-width, single-mode tone detection FSM.

## Interface
- `FFT_SIZE`, 2048: bins per frame; power of two.
- `NUM_TONES`, 8: number of detectable tones; the bin table comes from the package.
- `SPREAD`, 1: window half-width; tone k energy sums bins `TONE_BIN[k]-SPREAD .. TONE_BIN[k]+SPREAD`.
- `HOLD_FRAMES`, 3: consecutive identical frame decisions required before a report; ≥1.
- `clk_in`  in  1  system clock; one clock domain.
- `rst_in`  in  1  reset, synchronous, active-high.
- `fft_tvalid`  in  1  FFT beat valid.
- `fft_tready`  out  1  block accepts beat.
- `fft_tlast`  in  1  final bin of frame.
- `fft_tdata`  in  32  `{imag[31:16], real[15:0]}`, signed two's complement.
- `threshold`  in  EW  minimum winning energy; sampled in DECIDE.
- `tone_valid`  out  1  report pending.
- `tone_ready`  in  1  consumer accepts report.
- `tone_ident`  out  $clog2(NUM_TONES)  reported tone index.
- `tone_energy`  out  EW  winning energy of the reported frame.
- `frame_error`  out  1  one-cycle pulse on a malformed frame.

## Operation
- Magnitude per beat: `|re|+|im|`, 17 bits unsigned (|-32768| = 32768 fits). EW = 17 + $clog2(2*SPREAD+1).
- States: ACCUM → DECIDE → UPDATE → (REPORT | ACCUM).
- ACCUM: `fft_tready`=1. Bin counter 0..FFT_SIZE-1 increments on each accepted beat. The registered magnitude is added to every energy accumulator whose window contains the bin.
- Frame end is the accepted beat with `fft_tlast`=1 at count FFT_SIZE-1.
- Early `tlast` (count < FFT_SIZE-1), or count FFT_SIZE-1 without `tlast`:
  - Pulse `frame_error`, discard the frame, clear the accumulators and hold counter, and return to count 0 in ACCUM.
  - No decision is made for that frame.
- DECIDE: sequential argmax, one tone per cycle (NUM_TONES cycles). Ties go to the lowest index. If the winning energy < `threshold`, the candidate is SILENCE.
- UPDATE:
  - Candidate equal to the previous candidate: hold_cnt increments, saturating at HOLD_FRAMES. Otherwise hold_cnt=1.
  - When hold_cnt reaches HOLD_FRAMES and the candidate is a tone different from `last_reported`, load the outputs and go to REPORT. Otherwise go to ACCUM.
  - A stable SILENCE candidate clears `last_reported` without reporting, so the same tone after a gap is reported again.
- REPORT: `tone_valid`=1 with `tone_ident`/`tone_energy` stable until `tone_ready`. `fft_tready`=0 throughout, so the FFT is backpressured. Leave on the handshake cycle for ACCUM.
- Accumulators clear on entry to ACCUM.

## Timing
- Reset values: `fft_tready`=0, `tone_valid`=0, `tone_ident`=0, `tone_energy`=0, `frame_error`=0; state ACCUM, count 0, hold_cnt 0, `last_reported`=none. `fft_tready`=1 from the first cycle after reset deasserts.
- For a last beat accepted at cycle T:
  - Accumulate at T+1.
  - DECIDE at T+2 .. T+1+NUM_TONES.
  - UPDATE at T+2+NUM_TONES.
  - `tone_valid` rises at T+3+NUM_TONES, or `fft_tready` returns at T+3+NUM_TONES if there is no report.
- `fft_tready`=0 from T+1 until back in ACCUM.
- `frame_error` asserts the cycle after the offending beat.
- Reset mid-frame or mid-report drops all state; no report survives.
- `tone_ready` held high before `tone_valid`: handshake completes in the first valid cycle.

## Structure
- Package `tone_detect_pkg`:
  - `TONE_BIN[NUM_TONES]` table (all entries in SPREAD..FFT_SIZE/2-1-SPREAD).
  - `state_t` enum.
  - SILENCE encoding.
  - MAG_W = 17 and the EW helper function.
- Sub-module `fft_bin_magnitude`: one registered stage, from `fft_tdata` + valid to 17-bit magnitude + bin index.

## Test plan
- Bin `TONE_BIN[3]` = {1000,0}, all others 0, `threshold`=500, 3 frames → single report, ident 3, energy 1000; frames 4-5 same tone → no further report.
- Same as above but `threshold`=2000 → no report ever; `frame_error` stays 0.
- Equal energy 800 in tones 2 and 5 for 3 frames → ident 2.
- `tlast` at bin 100 → `frame_error` pulse; next 3 good frames of tone 1 → exactly one report (ident 1).
- Tone 4 reported, then `tone_ready` held 0 for 50 cycles → `tone_valid` and data stable, `fft_tready`=0; then tone 4 ×3, silence ×3, tone 4 ×3 → second report of ident 4.
- `rst_in` pulse at bin 1024 of frame 2 → all outputs 0; 3 fresh frames are needed before any report.
